// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and types for the butterfly input stage.
// Holds the default fixed-point format, the lane count, a 16-lane complex
// vector type at the default width, and the reorder-buffer FSM states.
package fft_pkg;

    localparam int SIG_DEF   = 1;
    localparam int INT_DEF   = 2;
    localparam int FLT_DEF   = 6;
    localparam int WIDTH_DEF = SIG_DEF + INT_DEF + FLT_DEF;
    localparam int LANES     = 16;

    typedef logic signed [WIDTH_DEF-1:0] sample_t;

    // One 16-lane I/Q vector at the default sample width.
    typedef struct packed {
        sample_t [LANES-1:0] re;
        sample_t [LANES-1:0] im;
    } cplx_vec_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_PAIR = 2'd2
    } buf_state_e;

    // Bit offset of one component of one lane inside a flattened vector.
    // comp = 0 selects the real part, comp = 1 the imaginary part.
    function automatic int lane_ofs(input int lane, input int comp, input int width);
        return ((2 * lane) + comp) * width;
    endfunction

endpackage

// File: rtl/bfly_dly_mem.sv
// bfly_dly_mem: half-frame delay memory for the butterfly input stage.
// DEPTH entries of one flattened 16-lane I/Q vector. A single address is
// shared by the synchronous write port and the combinational read port, so
// a read returns the entry written DEPTH accepted vectors earlier.
module bfly_dly_mem #(
    parameter  int DEPTH = 16,
    parameter  int DW    = 288,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // Store the incoming vector at the shared address when enabled.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/bfly_buf.sv
// bfly_buf: input reorder/delay stage in front of the radix-2 butterfly.
// The first DEPTH vectors of a frame are stored; each of the next DEPTH
// vectors is presented on port 1 together with its stored partner on
// port 2, with bfly_en high for exactly those DEPTH cycles.
// Build option BFLY_BUF_ZERO_EN: when defined, all dout lanes are cleared
// on every cycle where bfly_en is low; otherwise they hold their value.
module bfly_buf
    import fft_pkg::*;
#(
    parameter int SIG   = SIG_DEF,
    parameter int INT   = INT_DEF,
    parameter int FLT   = FLT_DEF,
    parameter int WIDTH = SIG + INT + FLT,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    din_valid,
    input  logic signed [WIDTH-1:0] din_i   [0:LANES-1],
    input  logic signed [WIDTH-1:0] din_q   [0:LANES-1],
    output logic                    bfly_en,
    output logic signed [WIDTH-1:0] dout1_i [0:LANES-1],
    output logic signed [WIDTH-1:0] dout1_q [0:LANES-1],
    output logic signed [WIDTH-1:0] dout2_i [0:LANES-1],
    output logic signed [WIDTH-1:0] dout2_q [0:LANES-1],
    output logic                    frame_done,
    output logic                    err
);

    localparam int PW = $clog2(DEPTH);
    localparam int DW = LANES * 2 * WIDTH;

    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    buf_state_e    state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          err_q, err_d;
    logic          bfly_en_q;
    logic          frame_done_q;

    logic          mem_we_s;
    logic          pair_s;
    logic          done_s;
    logic [DW-1:0] wdata_s;
    logic [DW-1:0] rdata_s;

    logic signed [WIDTH-1:0] rd_i_s    [0:LANES-1];
    logic signed [WIDTH-1:0] rd_q_s    [0:LANES-1];
    logic signed [WIDTH-1:0] dout1_i_q [0:LANES-1];
    logic signed [WIDTH-1:0] dout1_q_q [0:LANES-1];
    logic signed [WIDTH-1:0] dout2_i_q [0:LANES-1];
    logic signed [WIDTH-1:0] dout2_q_q [0:LANES-1];
    logic signed [WIDTH-1:0] dout1_i_d [0:LANES-1];
    logic signed [WIDTH-1:0] dout1_q_d [0:LANES-1];
    logic signed [WIDTH-1:0] dout2_i_d [0:LANES-1];
    logic signed [WIDTH-1:0] dout2_q_d [0:LANES-1];

    // Flatten the input lanes into one memory word.
    always_comb begin
        wdata_s = {DW{1'b0}};
        for (int l = 0; l < LANES; l++) begin
            wdata_s[lane_ofs(l, 0, WIDTH) +: WIDTH] = din_i[l];
            wdata_s[lane_ofs(l, 1, WIDTH) +: WIDTH] = din_q[l];
        end
    end

    bfly_dly_mem #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we_s),
        .addr_i  (ptr_q),
        .wdata_i (wdata_s),
        .rdata_o (rdata_s)
    );

    // Split the stored word back into per-lane I/Q samples.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            rd_i_s[l] = rdata_s[lane_ofs(l, 0, WIDTH) +: WIDTH];
            rd_q_s[l] = rdata_s[lane_ofs(l, 1, WIDTH) +: WIDTH];
        end
    end

    // FSM next state, pointer advance, memory write and abort detection.
    // ptr is always zero in IDLE, so the IDLE write lands in entry 0.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        err_d    = err_q;
        mem_we_s = 1'b0;
        pair_s   = 1'b0;
        done_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (din_valid) begin
                    mem_we_s = 1'b1;
                    ptr_d    = PTR_ONE;
                    state_d  = ST_FILL;
                end else begin
                    ptr_d    = PTR_ZERO;
                end
            end
            ST_FILL: begin
                if (din_valid) begin
                    mem_we_s = 1'b1;
                    if (ptr_q == PTR_LAST) begin
                        ptr_d   = PTR_ZERO;
                        state_d = ST_PAIR;
                    end else begin
                        ptr_d   = ptr_q + PTR_ONE;
                    end
                end else begin
                    err_d   = 1'b1;
                    ptr_d   = PTR_ZERO;
                    state_d = ST_IDLE;
                end
            end
            ST_PAIR: begin
                if (din_valid) begin
                    pair_s = 1'b1;
                    if (ptr_q == PTR_LAST) begin
                        ptr_d   = PTR_ZERO;
                        done_s  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ptr_d   = ptr_q + PTR_ONE;
                    end
                end else begin
                    err_d   = 1'b1;
                    ptr_d   = PTR_ZERO;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                ptr_d   = PTR_ZERO;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output data next values: load the pair, otherwise hold or clear.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            if (pair_s) begin
                dout1_i_d[l] = din_i[l];
                dout1_q_d[l] = din_q[l];
                dout2_i_d[l] = rd_i_s[l];
                dout2_q_d[l] = rd_q_s[l];
            end else begin
`ifdef BFLY_BUF_ZERO_EN
                dout1_i_d[l] = {WIDTH{1'b0}};
                dout1_q_d[l] = {WIDTH{1'b0}};
                dout2_i_d[l] = {WIDTH{1'b0}};
                dout2_q_d[l] = {WIDTH{1'b0}};
`else
                dout1_i_d[l] = dout1_i_q[l];
                dout1_q_d[l] = dout1_q_q[l];
                dout2_i_d[l] = dout2_i_q[l];
                dout2_q_d[l] = dout2_q_q[l];
`endif
            end
        end
    end

    // State, pointer, flags and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= PTR_ZERO;
            err_q        <= 1'b0;
            bfly_en_q    <= 1'b0;
            frame_done_q <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                dout1_i_q[l] <= {WIDTH{1'b0}};
                dout1_q_q[l] <= {WIDTH{1'b0}};
                dout2_i_q[l] <= {WIDTH{1'b0}};
                dout2_q_q[l] <= {WIDTH{1'b0}};
            end
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            err_q        <= err_d;
            bfly_en_q    <= pair_s;
            frame_done_q <= done_s;
            for (int l = 0; l < LANES; l++) begin
                dout1_i_q[l] <= dout1_i_d[l];
                dout1_q_q[l] <= dout1_q_d[l];
                dout2_i_q[l] <= dout2_i_d[l];
                dout2_q_q[l] <= dout2_q_d[l];
            end
        end
    end

    assign bfly_en    = bfly_en_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;
    assign dout1_i    = dout1_i_q;
    assign dout1_q    = dout1_q_q;
    assign dout2_i    = dout2_i_q;
    assign dout2_q    = dout2_q_q;

endmodule

// File: doc/bfly_buf.md
# bfly_buf

Input reorder and delay stage placed directly upstream of the radix-2 butterfly. It receives 16-lane complex sample vectors and stores the first half-frame (DEPTH cycles) in a delay memory. During the second half-frame it presents each new vector together with the stored vector that arrived DEPTH cycles earlier, so the butterfly sees x[n+N/2] on port 1 and x[n] on port 2. It also generates the butterfly's `bfly_en`, which stays high for exactly the pairing phase.

## Interface
Parameters:
- `SIG`, default 1: sign bits.
- `INT`, default 2: integer bits.
- `FLT`, default 6: fraction bits.
- `WIDTH`, default SIG+INT+FLT: sample width in bits.
- `DEPTH`, default 16: half-frame length in cycles. Must be a power of two, ≥2.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: reset, **synchronous, active-high**.
- `din_valid`, in, 1: input vector valid this cycle.
- `din_i[0:15]`, in, signed WIDTH each: input real part, 16 lanes.
- `din_q[0:15]`, in, signed WIDTH each: input imaginary part, 16 lanes.
- `bfly_en`, out, 1: butterfly enable; high on every cycle the pair outputs are valid.
- `dout1_i[0:15]`, `dout1_q[0:15]`, out, signed WIDTH each: current (late) vector, i.e. x[n+N/2].
- `dout2_i[0:15]`, `dout2_q[0:15]`, out, signed WIDTH each: delayed (early) vector, i.e. x[n].
- `frame_done`, out, 1: one-cycle pulse on the last pair cycle of a frame.
- `err`, out, 1: sticky flag, set when a frame is aborted; cleared only by `rst`.

## Operation
- State machine: IDLE, FILL, PAIR.
- Pointer `ptr`: 0..DEPTH-1, width $clog2(DEPTH). It addresses the delay memory in both FILL and PAIR.
- IDLE:
  - `din_valid`=1 → write `din` to mem[0], set `ptr`=1, go to FILL.
  - With DEPTH=1 this would go straight to PAIR; that case is illegal by the DEPTH rule.
- FILL, on each valid cycle:
  - Write `din` to mem[`ptr`] and increment `ptr`.
  - On the write at `ptr`=DEPTH-1: wrap `ptr` to 0 and go to PAIR.
- PAIR, on each valid cycle:
  - Register `din` into `dout1` and mem[`ptr`] into `dout2`.
  - Increment `ptr`.
  - At `ptr`=DEPTH-1: wrap to 0, pulse `frame_done`, return to IDLE.
- Back-to-back frames: a valid vector in the cycle after the last PAIR cycle is taken by IDLE as sample 0 of the next frame. The gap is zero cycles.
- Frame abort: frames must arrive gap-free. If `din_valid`=0 while in FILL or PAIR:
  - Set `err`.
  - Return to IDLE with `ptr`=0.
  - Discard the partial frame; memory contents are don't-care.
- In IDLE, `din_valid`=0 is normal and does not set `err`.
- Arithmetic: pass-through only. No width growth, no rounding; lanes map 1:1.

## Timing
- Reset values: state=IDLE, `ptr`=0, `bfly_en`=0, `frame_done`=0, `err`=0, all `dout*`=0. Memory is not reset.
- Latency: a vector accepted in PAIR at edge k appears on `dout1`/`dout2` after edge k, with `bfly_en`=1 in that same cycle. The result is one register stage.
- Pairing: the vector accepted on FILL cycle j pairs with the vector accepted on PAIR cycle j.
- `bfly_en` is high for exactly DEPTH consecutive cycles per completed frame. It never toggles inside a frame.
- `frame_done` coincides with the last `bfly_en`=1 cycle.
- Abort: the abort occurs in the cycle where `din_valid` drops. From the following cycle, `bfly_en`=0 and `err`=1.
- `rst` asserted mid-frame: on the next edge, all outputs return to their reset values. There is no `frame_done` pulse and `err` is not set.
- Outputs hold their last value when `bfly_en`=0 (see Configuration).

## Configuration
- Macro: `BFLY_BUF_ZERO_EN`.
  - Defined: every `dout*` lane is forced to 0 on each cycle where `bfly_en`=0. This gives a clean zero output between frames, intended for power and debugging.
  - Undefined: `dout*` registers load only on PAIR cycles and otherwise hold their value.
- `bfly_en`, `frame_done` and `err` behave identically in both builds.

## Structure
- `fft_pkg` holds:
  - the default SIG/INT/FLT values;
  - `LANES`=16;
  - a `cplx_vec_t` typedef for one 16-lane I/Q vector;
  - the FSM state enum `buf_state_e`.
- One sub-module, `bfly_dly_mem`: a DEPTH × (16·2·WIDTH) register-file memory with one write port and one read port at a shared address, plus a write enable. The read is combinational.
- The FSM, pointer, output registers and flags live in `bfly_buf`.

## Test plan
All scenarios use DEPTH=4.
- **Single frame.** Lane 0 real parts: 1,2,3,4 in FILL, then 5,6,7,8 in PAIR.
  - Required: `bfly_en` high 4 cycles; (dout1, dout2) = (5,1), (6,2), (7,3), (8,4).
  - Required: `frame_done` on the (8,4) cycle.
- **Back-to-back frames.** 16 consecutive valid vectors.
  - Required: two 4-cycle `bfly_en` bursts separated by exactly 4 low cycles.
  - Required: second frame pairs (13,9)…(16,12).
- **Gap in FILL.** `din_valid` drops after 2 FILL vectors.
  - Required: `err`=1 on the next cycle, state IDLE.
  - Required: a following clean frame pairs correctly and `err` stays 1.
- **Gap in PAIR.** `din_valid` drops after 2 pair cycles.
  - Required: `bfly_en` falls on the next cycle, no `frame_done`, `err`=1.
- **Mid-frame reset.** `rst` pulsed during PAIR.
  - Required: all outputs 0 after the edge, `err`=0, the next frame works.
- **Lane / sign integrity.** Lane L is fed −L in FILL and +L in PAIR.
  - Required: every lane pairs (+L, −L), checked in both macro builds.
  - Required: with `BFLY_BUF_ZERO_EN` defined, `dout*` are 0 between frames.
